alu_driver: RTL and testbench
=============================

ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 SHALL have parameter dataBits, default 8, the operand/result width.
REQ-002 SHALL have ports in this order:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have request ports:
- req_valid  in  1  request offered.
- req_ready  out  1  driver can accept a request.
- req_func  in  4  ALU function code.
- req_condition  in  4  condition code.
REQ-004 SHALL have stack pop ports:
- pop_valid  in  1  stack word available.
- pop_ready  out  1  driver consumes the word.
- pop_data  in  dataBits  top-of-stack word.
REQ-005 SHALL have stack push ports:
- push_valid  out  1  result offered.
- push_ready  in  1  stack accepts the result.
- push_data  out  dataBits  result word.
REQ-006 SHALL have ALU-facing ports:
- aluA, aluB  out  dataBits  operands.
- func, condition  out  4  registered copies of the request codes.
- updateFlags  out  1  flag-capture strobe.
- aluOut  in  dataBits  combinational result.
- conditionHolds  in  1  registered condition result.
REQ-007 SHALL have completion ports:
- done_valid  out  1  one-cycle completion pulse.
- done_condition  out  1  conditionHolds captured for the operation.
- error  out  1  one-cycle underflow pulse.
- stack_empty  in  1  stack holds no words.

Function
REQ-008 SHALL implement the states IDLE, POP_B, POP_A, EXEC, SETTLE, PUSH and DONE.
REQ-009 In IDLE, req_ready SHALL be 1; on req_valid&&req_ready it SHALL latch func and condition and go to POP_B, or to POP_A when req_func==`OP_ALU_NOT.
REQ-010 In POP_B, pop_ready SHALL be 1; on pop_valid it SHALL load aluB from pop_data and go to POP_A.
REQ-011 In POP_A, pop_ready SHALL be 1; on pop_valid it SHALL load aluA from pop_data and go to EXEC.
REQ-012 For NOT, aluB SHALL be 0.
REQ-013 Operand order SHALL be: first pop (top of stack) is aluB, second pop is aluA, so A-B matches push order.
REQ-014 In EXEC, updateFlags SHALL be 1 for exactly one cycle, and aluOut SHALL be captured into push_data; the state SHALL then go to SETTLE.
REQ-015 In SETTLE, conditionHolds SHALL be captured into done_condition.
REQ-016 From SETTLE the state SHALL go to DONE when func==`OP_ALU_COMPARE, otherwise to PUSH.
REQ-017 In PUSH, push_valid SHALL be held with push_data stable until push_ready, then the state SHALL go to DONE; push_ready asserted early SHALL be ignored.
REQ-018 DONE SHALL pulse done_valid for one cycle and return to IDLE.
REQ-019 Minimum latency SHALL be 6 cycles from request accept to done_valid (binary, pop and push ready every cycle); NOT SHALL take 5 cycles; COMPARE SHALL take 5 cycles.
REQ-020 Outside the states named above, pop_ready, push_valid, updateFlags and done_valid SHALL be 0.
REQ-021 req_valid outside IDLE SHALL be ignored; there is one outstanding operation.
REQ-022 aluA, aluB, func and condition SHALL hold their values until the next accept.

Reset
REQ-023 Reset SHALL force IDLE and clear all registers to 0, overriding any in-flight handshake.
REQ-024 A result pending in PUSH SHALL be discarded by reset.
REQ-025 Popped operands SHALL not be restored by reset.

Configuration
REQ-026 With ALU_DRIVER_UNDERFLOW_EN defined:
- stack_empty high in POP_B/POP_A SHALL abort to IDLE;
- error SHALL pulse for one cycle;
- no updateFlags and no done_valid SHALL be issued.
REQ-027 Without ALU_DRIVER_UNDERFLOW_EN, stack_empty SHALL be ignored and error SHALL be tied to 0.

Structure
REQ-028 ALU function and condition codes SHALL come from the shared opcode definitions.
REQ-029 State encodings SHALL be local constants.
REQ-030 No sub-module SHALL be used; the bench SHALL instantiate the existing Alu with alu_driver.

Verification
REQ-031 ADD, pops 12 then 116 -> aluA=116, aluB=12, push_data=128, done_valid at cycle 6.
REQ-032 COMPARE `OP_CONDITION_SIGNED_LESS, pops 10 then 200 -> done_condition=1, push_valid never asserted.
REQ-033 NOT, pop 116 -> exactly one pop, push_data=139, aluB=0.
REQ-034 SUB 116-12 with push_ready held low for 3 cycles -> push_valid and push_data=104 held stable for 4 cycles, then done_valid.
REQ-035 Reset asserted in PUSH -> next cycle IDLE, push_valid=0, req_ready=1.
REQ-036 With ALU_DRIVER_UNDERFLOW_EN, stack_empty=1 in POP_B -> error pulse, updateFlags never 1, back to IDLE.

Source files
------------

// File: rtl/alu_driver_pkg.sv
// Shared ALU opcode/condition definitions and request payload for alu_driver.
package alu_driver_pkg;

  localparam int unsigned FUNC_W = 4;
  localparam int unsigned COND_W = 4;

  localparam logic [FUNC_W-1:0] OP_ALU_ADD     = 4'h0;
  localparam logic [FUNC_W-1:0] OP_ALU_SUB     = 4'h1;
  localparam logic [FUNC_W-1:0] OP_ALU_AND     = 4'h2;
  localparam logic [FUNC_W-1:0] OP_ALU_OR      = 4'h3;
  localparam logic [FUNC_W-1:0] OP_ALU_XOR     = 4'h4;
  localparam logic [FUNC_W-1:0] OP_ALU_NOT     = 4'h5;
  localparam logic [FUNC_W-1:0] OP_ALU_COMPARE = 4'h6;

  localparam logic [COND_W-1:0] OP_CONDITION_NEVER         = 4'h0;
  localparam logic [COND_W-1:0] OP_CONDITION_ALWAYS        = 4'h1;
  localparam logic [COND_W-1:0] OP_CONDITION_EQUAL         = 4'h2;
  localparam logic [COND_W-1:0] OP_CONDITION_NOT_EQUAL     = 4'h3;
  localparam logic [COND_W-1:0] OP_CONDITION_UNSIGNED_LESS = 4'h4;
  localparam logic [COND_W-1:0] OP_CONDITION_SIGNED_LESS   = 4'h5;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [COND_W-1:0] condition;
  } alu_req_t;

  // Single-operand functions skip the aluB pop.
  function automatic logic is_unary(input logic [FUNC_W-1:0] f);
    return f == OP_ALU_NOT;
  endfunction

  // Flag-only functions produce no stack result.
  function automatic logic is_flag_only(input logic [FUNC_W-1:0] f);
    return f == OP_ALU_COMPARE;
  endfunction

endpackage

// File: rtl/alu_driver.sv
// Sequences one stack-machine ALU operation: pop operands, execute, push result.
// Optional ALU_DRIVER_UNDERFLOW_EN aborts on an empty stack with an error pulse.
module alu_driver
  import alu_driver_pkg::*;
#(
  parameter int unsigned dataBits = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [FUNC_W-1:0]   req_func,
  input  logic [COND_W-1:0]   req_condition,
  input  logic                pop_valid,
  output logic                pop_ready,
  input  logic [dataBits-1:0] pop_data,
  output logic                push_valid,
  input  logic                push_ready,
  output logic [dataBits-1:0] push_data,
  output logic [dataBits-1:0] aluA,
  output logic [dataBits-1:0] aluB,
  output logic [FUNC_W-1:0]   func,
  output logic [COND_W-1:0]   condition,
  output logic                updateFlags,
  input  logic [dataBits-1:0] aluOut,
  input  logic                conditionHolds,
  output logic                done_valid,
  output logic                done_condition,
  output logic                error,
  input  logic                stack_empty
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP_B  = 3'd1,
    ST_POP_A  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_SETTLE = 3'd4,
    ST_PUSH   = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  state_e                state_q;
  logic                  busy_q;
  logic                  pop_ready_q;
  logic                  push_valid_q;
  logic                  update_flags_q;
  logic                  done_valid_q;
  logic                  done_cond_q;
  alu_req_t              req_q;
  logic [dataBits-1:0]   alu_a_q;
  logic [dataBits-1:0]   alu_b_q;
  logic [dataBits-1:0]   push_data_q;
  logic                  underflow_c;

`ifdef ALU_DRIVER_UNDERFLOW_EN
  logic error_q;
  assign underflow_c = stack_empty;
  assign error       = error_q;
`else
  logic unused_stack_empty_c;
  assign unused_stack_empty_c = stack_empty;
  assign underflow_c          = 1'b0;
  assign error                = 1'b0;
`endif

  // busy_q resets to 0 so the idle-ready output comes out of reset high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      busy_q         <= 1'b0;
      pop_ready_q    <= 1'b0;
      push_valid_q   <= 1'b0;
      update_flags_q <= 1'b0;
      done_valid_q   <= 1'b0;
      done_cond_q    <= 1'b0;
      req_q          <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      push_data_q    <= '0;
`ifdef ALU_DRIVER_UNDERFLOW_EN
      error_q        <= 1'b0;
`endif
    end else begin
      update_flags_q <= 1'b0;
      done_valid_q   <= 1'b0;
`ifdef ALU_DRIVER_UNDERFLOW_EN
      error_q        <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            req_q.func      <= req_func;
            req_q.condition <= req_condition;
            busy_q          <= 1'b1;
            pop_ready_q     <= 1'b1;
            if (is_unary(req_func)) begin
              alu_b_q <= '0;
              state_q <= ST_POP_A;
            end else begin
              state_q <= ST_POP_B;
            end
          end
        end
        ST_POP_B: begin
          if (underflow_c) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            pop_ready_q <= 1'b0;
`ifdef ALU_DRIVER_UNDERFLOW_EN
            error_q     <= 1'b1;
`endif
          end else if (pop_valid) begin
            alu_b_q <= pop_data;
            state_q <= ST_POP_A;
          end
        end
        ST_POP_A: begin
          if (underflow_c) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            pop_ready_q <= 1'b0;
`ifdef ALU_DRIVER_UNDERFLOW_EN
            error_q     <= 1'b1;
`endif
          end else if (pop_valid) begin
            alu_a_q        <= pop_data;
            pop_ready_q    <= 1'b0;
            update_flags_q <= 1'b1;
            state_q        <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          push_data_q <= aluOut;
          state_q     <= ST_SETTLE;
        end
        // The ALU registers its condition during EXEC; it is readable here.
        ST_SETTLE: begin
          done_cond_q <= conditionHolds;
          if (is_flag_only(req_q.func)) begin
            done_valid_q <= 1'b1;
            state_q      <= ST_DONE;
          end else begin
            push_valid_q <= 1'b1;
            state_q      <= ST_PUSH;
          end
        end
        ST_PUSH: begin
          if (push_ready) begin
            push_valid_q <= 1'b0;
            done_valid_q <= 1'b1;
            state_q      <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q      <= ST_IDLE;
          busy_q       <= 1'b0;
          pop_ready_q  <= 1'b0;
          push_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready      = ~busy_q;
  assign pop_ready      = pop_ready_q;
  assign push_valid     = push_valid_q;
  assign push_data      = push_data_q;
  assign aluA           = alu_a_q;
  assign aluB           = alu_b_q;
  assign func           = req_q.func;
  assign condition      = req_q.condition;
  assign updateFlags    = update_flags_q;
  assign done_valid     = done_valid_q;
  assign done_condition = done_cond_q;

endmodule

// File: tb/tb_alu_driver.sv
// Self-checking bench for alu_driver with a behavioural ALU stand-in.
module tb_alu_driver;
  import alu_driver_pkg::*;

  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready;
  logic [3:0]    req_func, req_condition;
  logic          pop_valid, pop_ready;
  logic [DW-1:0] pop_data;
  logic          push_valid, push_ready;
  logic [DW-1:0] push_data, aluA, aluB, alu_out;
  logic [3:0]    func_o, cond_o;
  logic          updateFlags, cond_holds;
  logic          done_valid, done_condition, error, stack_empty;

  int checks = 0;
  int failures = 0;
  int err_cnt = 0;
  int upd_cnt = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  alu_driver #(.dataBits(DW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_func(req_func), .req_condition(req_condition),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .aluA(aluA), .aluB(aluB), .func(func_o), .condition(cond_o),
    .updateFlags(updateFlags), .aluOut(alu_out), .conditionHolds(cond_holds),
    .done_valid(done_valid), .done_condition(done_condition),
    .error(error), .stack_empty(stack_empty)
  );

  function automatic logic [DW-1:0] model_result(input logic [3:0] f, input logic [DW-1:0] a, b);
    case (f)
      OP_ALU_ADD:     return DW'(a + b);
      OP_ALU_SUB:     return DW'(a - b);
      OP_ALU_AND:     return a & b;
      OP_ALU_OR:      return a | b;
      OP_ALU_XOR:     return a ^ b;
      OP_ALU_NOT:     return ~a;
      OP_ALU_COMPARE: return DW'(a - b);
      default:        return '0;
    endcase
  endfunction

  function automatic logic model_cond(input logic [3:0] c, input logic [DW-1:0] a, b, r);
    case (c)
      OP_CONDITION_ALWAYS:        return 1'b1;
      OP_CONDITION_EQUAL:         return r == '0;
      OP_CONDITION_NOT_EQUAL:     return r != '0;
      OP_CONDITION_UNSIGNED_LESS: return a < b;
      OP_CONDITION_SIGNED_LESS:   return $signed(a) < $signed(b);
      default:                    return 1'b0;
    endcase
  endfunction

  // ALU stand-in: combinational result, condition registered on updateFlags.
  assign alu_out = model_result(func_o, aluA, aluB);
  always @(posedge clk) begin
    if (reset) cond_holds <= 1'b0;
    else if (updateFlags) cond_holds <= model_cond(cond_o, aluA, aluB, alu_out);
    if (error) err_cnt <= err_cnt + 1;
    if (updateFlags) upd_cnt <= upd_cnt + 1;
    if (done_valid) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s id=%0d actual=%0d expected=%0d", name, id, act, exp);
    end
  endtask

  task automatic run_op(input int id, input logic [3:0] f, c, input logic [DW-1:0] b, a, exp_res,
                        input logic exp_cond, input bit exp_push, input int exp_lat,
                        input int push_delay, input bit stall, input bit noise);
    logic [DW-1:0] words[$];
    logic [DW-1:0] got;
    int idx, lat, push_cycles, flag_cycles;
    bit stable, fire, unary;
    idx = 0; lat = 0; push_cycles = 0; flag_cycles = 0; stable = 1'b1; got = '0;
    unary = (f == OP_ALU_NOT);
    if (!unary) words.push_back(b);
    words.push_back(a);
    @(negedge clk);
    chk("req_ready_idle", id, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_func = f; req_condition = c; pop_valid = 1'b0; push_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (done_valid) begin
        lat = cyc;
        break;
      end
      if (updateFlags) flag_cycles++;
      if (push_valid) begin
        push_cycles++;
        if (push_cycles == 1) got = push_data;
        else if (push_data !== got) stable = 1'b0;
      end
      if (idx < words.size()) begin
        pop_valid = !stall || ($urandom_range(0, 3) != 0);
        pop_data  = words[idx];
      end else begin
        pop_valid = 1'b0;
        pop_data  = DW'($urandom);
      end
      push_ready    = push_valid ? (push_cycles > push_delay) : 1'b1;
      req_valid     = noise && ($urandom_range(0, 1) == 1);
      req_func      = 4'($urandom);
      req_condition = 4'($urandom);
      fire = pop_ready && pop_valid;
      @(posedge clk); #1;
      if (fire) idx++;
    end
    req_valid = 1'b0; pop_valid = 1'b0;
    chk("done_seen", id, 32'(lat != 0), 32'd1);
    if (exp_lat != 0) chk("latency", id, 32'(lat), 32'(exp_lat));
    chk("pop_count", id, 32'(idx), unary ? 32'd1 : 32'd2);
    chk("update_flags_cycles", id, 32'(flag_cycles), 32'd1);
    chk("aluA", id, 32'(aluA), 32'(a));
    chk("aluB", id, 32'(aluB), unary ? 32'd0 : 32'(b));
    chk("func", id, 32'(func_o), 32'(f));
    chk("condition", id, 32'(cond_o), 32'(c));
    chk("done_condition", id, 32'(done_condition), 32'(exp_cond));
    if (exp_push) begin
      chk("push_cycles", id, 32'(push_cycles), 32'(push_delay + 1));
      chk("push_data", id, 32'(got), 32'(exp_res));
      chk("push_stable", id, 32'(stable), 32'd1);
    end else begin
      chk("no_push", id, 32'(push_cycles), 32'd0);
    end
    @(posedge clk); #1;
    chk("done_pulse", id, 32'(done_valid), 32'd0);
    chk("back_idle", id, 32'(req_ready), 32'd1);
  endtask

  typedef struct {
    logic [3:0]    f;
    logic [3:0]    c;
    logic [DW-1:0] b;
    logic [DW-1:0] a;
    logic [DW-1:0] res;
    logic          cnd;
    bit            do_push;
    int            lat;
  } vec_t;

  vec_t vecs[12];
  logic [3:0] funcs[7];

  initial begin
    int d0, d1;
    logic [3:0] f, c;
    logic [DW-1:0] a, b, r;
    vecs[0]  = '{OP_ALU_ADD,     OP_CONDITION_ALWAYS,        8'd12,   8'd116,  8'd128,  1'b1, 1'b1, 6};
    vecs[1]  = '{OP_ALU_COMPARE, OP_CONDITION_SIGNED_LESS,   8'd10,   8'd200,  8'd0,    1'b1, 1'b0, 5};
    vecs[2]  = '{OP_ALU_NOT,     OP_CONDITION_ALWAYS,        8'd0,    8'd116,  8'd139,  1'b1, 1'b1, 5};
    vecs[3]  = '{OP_ALU_SUB,     OP_CONDITION_NEVER,         8'd12,   8'd116,  8'd104,  1'b0, 1'b1, 6};
    vecs[4]  = '{OP_ALU_AND,     OP_CONDITION_EQUAL,         8'h3C,   8'hF0,   8'h30,   1'b0, 1'b1, 6};
    vecs[5]  = '{OP_ALU_COMPARE, OP_CONDITION_EQUAL,         8'd55,   8'd55,   8'd0,    1'b1, 1'b0, 5};
    vecs[6]  = '{OP_ALU_COMPARE, OP_CONDITION_UNSIGNED_LESS, 8'd10,   8'd200,  8'd0,    1'b0, 1'b0, 5};
    vecs[7]  = '{OP_ALU_ADD,     OP_CONDITION_EQUAL,         8'd100,  8'd156,  8'd0,    1'b1, 1'b1, 6};
    vecs[8]  = '{OP_ALU_XOR,     OP_CONDITION_NOT_EQUAL,     8'hFF,   8'hAA,   8'h55,   1'b1, 1'b1, 6};
    vecs[9]  = '{OP_ALU_OR,      OP_CONDITION_ALWAYS,        8'hF0,   8'h0F,   8'hFF,   1'b1, 1'b1, 6};
    vecs[10] = '{OP_ALU_COMPARE, OP_CONDITION_SIGNED_LESS,   8'd200,  8'd10,   8'd0,    1'b0, 1'b0, 5};
    vecs[11] = '{OP_ALU_NOT,     OP_CONDITION_EQUAL,         8'd0,    8'hFF,   8'h00,   1'b1, 1'b1, 5};
    funcs = '{OP_ALU_ADD, OP_ALU_SUB, OP_ALU_AND, OP_ALU_OR, OP_ALU_XOR, OP_ALU_NOT, OP_ALU_COMPARE};

    reset = 1'b1; req_valid = 1'b0; req_func = '0; req_condition = '0;
    pop_valid = 1'b0; pop_data = '0; push_ready = 1'b0; stack_empty = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 0, 32'(req_ready), 32'd1);
    chk("rst_pop_ready", 0, 32'(pop_ready), 32'd0);
    chk("rst_push_valid", 0, 32'(push_valid), 32'd0);
    chk("rst_done_valid", 0, 32'(done_valid), 32'd0);
    chk("rst_error", 0, 32'(error), 32'd0);
    chk("rst_operands", 0, 32'({aluA, aluB, push_data}), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++)
      run_op(i, vecs[i].f, vecs[i].c, vecs[i].b, vecs[i].a, vecs[i].res, vecs[i].cnd,
             vecs[i].do_push, vecs[i].lat, 0, 1'b0, 1'b0);

    // Push back-pressure: three cycles of push_ready low stretch latency by three.
    run_op(100, OP_ALU_SUB, OP_CONDITION_ALWAYS, 8'd12, 8'd116, 8'd104, 1'b1, 1'b1, 9, 3, 1'b0, 1'b0);

    // Reset while a result waits in PUSH discards it.
    @(negedge clk);
    req_valid = 1'b1; req_func = OP_ALU_SUB; req_condition = OP_CONDITION_ALWAYS; push_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; pop_valid = 1'b1; pop_data = 8'd12;
    @(posedge clk); #1;
    pop_data = 8'd116;
    @(posedge clk); #1;
    pop_valid = 1'b0;
    for (int i = 0; i < 8 && !push_valid; i++) begin
      @(posedge clk); #1;
    end
    chk("rp_reached_push", 200, 32'(push_valid), 32'd1);
    chk("rp_push_data", 200, 32'(push_data), 32'd104);
    d0 = done_cnt;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rp_push_valid", 200, 32'(push_valid), 32'd0);
    chk("rp_req_ready", 200, 32'(req_ready), 32'd1);
    chk("rp_aluA_cleared", 200, 32'(aluA), 32'd0);
    push_ready = 1'b1;
    d1 = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (push_valid || done_valid) d1++;
    end
    chk("rp_no_stale", 200, 32'(d1), 32'd0);
    chk("rp_no_done", 200, 32'(done_cnt - d0), 32'd0);
    run_op(201, vecs[0].f, vecs[0].c, vecs[0].b, vecs[0].a, vecs[0].res, vecs[0].cnd, 1'b1, 6, 0, 1'b0, 1'b0);

`ifdef ALU_DRIVER_UNDERFLOW_EN
    // Empty stack in POP_B (at=1) and in POP_A (at=2) aborts the operation.
    for (int at = 1; at <= 2; at++) begin
      d0 = upd_cnt; d1 = done_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_func = OP_ALU_ADD; req_condition = OP_CONDITION_ALWAYS;
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (at == 2) begin
        pop_valid = 1'b1; pop_data = 8'd9;
        @(posedge clk); #1;
        pop_valid = 1'b0;
      end
      chk("uf_in_pop", 300 + at, 32'(pop_ready), 32'd1);
      stack_empty = 1'b1;
      @(posedge clk); #1;
      stack_empty = 1'b0;
      chk("uf_error", 300 + at, 32'(error), 32'd1);
      chk("uf_idle", 300 + at, 32'(req_ready), 32'd1);
      chk("uf_pop_ready", 300 + at, 32'(pop_ready), 32'd0);
      @(posedge clk); #1;
      chk("uf_error_pulse", 300 + at, 32'(error), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("uf_no_update", 300 + at, 32'(upd_cnt - d0), 32'd0);
      chk("uf_no_done", 300 + at, 32'(done_cnt - d1), 32'd0);
    end
    run_op(310, vecs[3].f, vecs[3].c, vecs[3].b, vecs[3].a, vecs[3].res, vecs[3].cnd, 1'b1, 6, 0, 1'b0, 1'b0);
`else
    stack_empty = 1'b1;
    run_op(300, vecs[0].f, vecs[0].c, vecs[0].b, vecs[0].a, vecs[0].res, vecs[0].cnd, 1'b1, 6, 0, 1'b0, 1'b0);
    stack_empty = 1'b0;
`endif

    // Random operations: first clean timing, then with stalls and stray requests.
    for (int i = 0; i < 50; i++) begin
      f = funcs[$urandom_range(0, 6)];
      c = 4'($urandom_range(0, 5));
      a = DW'($urandom);
      b = (f == OP_ALU_NOT) ? '0 : DW'($urandom);
      r = model_result(f, a, b);
      if (i < 20)
        run_op(400 + i, f, c, b, a, r, model_cond(c, a, b, r), f != OP_ALU_COMPARE,
               (f == OP_ALU_NOT || f == OP_ALU_COMPARE) ? 5 : 6, 0, 1'b0, 1'b0);
      else
        run_op(400 + i, f, c, b, a, r, model_cond(c, a, b, r), f != OP_ALU_COMPARE,
               0, int'($urandom_range(0, 3)), 1'b1, 1'b1);
    end

`ifdef ALU_DRIVER_UNDERFLOW_EN
    chk("error_pulses", 999, 32'(err_cnt), 32'd2);
`else
    chk("error_pulses", 999, 32'(err_cnt), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
